// File: rtl/thirty_two_bit_adder.sv
// rtl/thirty_two_bit_adder.sv - registered 32-bit carry-lookahead adder; optional flags under ADDER_FLAGS_EN
module thirty_two_bit_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef ADDER_FLAGS_EN
    output logic             overflow,
    output logic             zero,
    output logic             negative,
`endif
    output logic             out_valid
);

    localparam int NGROUP = WIDTH / GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             group_cin;
    logic             cj;
    logic             term;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead inside each group from its carry-in; group carry-outs ripple to the next group
    always_comb begin
        carry     = '0;
        cout_next = 1'b0;
        group_cin = cin;
        cj        = 1'b0;
        term      = 1'b0;
        for (int gi = 0; gi < NGROUP; gi++) begin
            for (int j = 0; j <= GROUP; j++) begin
                // all-propagate path from the group carry-in
                cj = group_cin;
                for (int k = 0; k < j; k++) begin
                    cj = cj & p[gi*GROUP + k];
                end
                // generate at bit k, propagated through bits k+1 .. j-1
                for (int k = 0; k < j; k++) begin
                    term = g[gi*GROUP + k];
                    for (int m = k + 1; m < j; m++) begin
                        term = term & p[gi*GROUP + m];
                    end
                    cj = cj | term;
                end
                if (j < GROUP) begin
                    carry[gi*GROUP + j] = cj;
                end
            end
            group_cin = cj;
        end
        cout_next = group_cin;
    end

    assign sum_next = p ^ carry;

    // Output register: reset clears, in_valid loads, otherwise hold the last result
    always_ff @(posedge clk) begin
        if (reset) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef ADDER_FLAGS_EN
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_next;
                cout     <= cout_next;
`ifdef ADDER_FLAGS_EN
                // signed overflow: carry into the sign bit differs from carry out of it
                overflow <= carry[WIDTH-1] ^ cout_next;
                zero     <= (sum_next == '0);
                negative <= sum_next[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_thirty_two_bit_adder.sv
// tb/tb_thirty_two_bit_adder.sv - directed-vector self-checking bench for thirty_two_bit_adder
module tb_thirty_two_bit_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        out_valid;
`ifdef ADDER_FLAGS_EN
    logic        overflow;
    logic        zero;
    logic        negative;
`endif

    int n_vec = 0;
    int n_err = 0;

    thirty_two_bit_adder #(.WIDTH(32), .GROUP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
`ifdef ADDER_FLAGS_EN
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // present one operand set for one cycle, then check the registered result
    task automatic add_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vc, input logic [31:0] esum, input logic ecout);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        @(posedge clk);
        #1;
        chk({tag, ".sum"},   {1'b0, sum},       {1'b0, esum});
        chk({tag, ".cout"},  {32'd0, cout},     {32'd0, ecout});
        chk({tag, ".valid"}, {32'd0, out_valid}, 33'd1);
    endtask

    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] ref33;
    logic [31:0] held_sum;
    logic        held_cout;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'd5;
        b        = 32'd5;
        cin      = 1'b0;

        // reset held two cycles with operands valid: operands dropped
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst.sum",   {1'b0, sum},        33'd0);
            chk("rst.cout",  {32'd0, cout},      33'd0);
            chk("rst.valid", {32'd0, out_valid}, 33'd0);
        end

        add_vec("post_rst", 32'd2, 32'd6, 1'b0, 32'd8, 1'b0);

        // back-to-back small values
        add_vec("s16_23",   32'd16,    32'd23,    1'b0, 32'd39,    1'b0);
        add_vec("s124_215", 32'd124,   32'd215,   1'b0, 32'd339,   1'b0);
        add_vec("s1504",    32'd1504,  32'd4120,  1'b0, 32'd5624,  1'b0);
        add_vec("s15031",   32'd15031, 32'd10154, 1'b0, 32'd25185, 1'b0);

        // carries across group and halfword boundaries
        add_vec("c65535_1",   32'd65535, 32'd1,     1'b0, 32'd65536,  1'b0);
        add_vec("c65535_653", 32'd65535, 32'd65153, 1'b0, 32'd130688, 1'b0);

        // wrap-around
        add_vec("w_max_1",  32'hFFFF_FFFF, 32'd1,        1'b0, 32'd0,        1'b1);
        add_vec("w_0_cin",  32'd0,         32'd0,        1'b1, 32'd1,        1'b0);
        add_vec("w_max_mx", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        add_vec("w_alt",    32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'd0,        1'b1);

`ifdef ADDER_FLAGS_EN
        add_vec("f_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0);
        chk("f_ovf.overflow", {32'd0, overflow}, 33'd1);
        chk("f_ovf.negative", {32'd0, negative}, 33'd1);
        chk("f_ovf.zero",     {32'd0, zero},     33'd0);
        add_vec("f_zero", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1);
        chk("f_zero.zero",     {32'd0, zero},     33'd1);
        chk("f_zero.overflow", {32'd0, overflow}, 33'd0);
        chk("f_zero.negative", {32'd0, negative}, 33'd0);
`endif

        // hold: in_valid low for three cycles keeps the last result
        add_vec("pre_hold", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        held_sum  = 32'h2345_6789;
        held_cout = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold.sum",   {1'b0, sum},        {1'b0, held_sum});
            chk("hold.cout",  {32'd0, cout},      {32'd0, held_cout});
            chk("hold.valid", {32'd0, out_valid}, 33'd0);
        end

        // reset wins over in_valid mid-stream
        add_vec("pre_rst2", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 1'b1);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'd100;
        b        = 32'd200;
        @(posedge clk);
        #1;
        chk("rst2.sum",   {1'b0, sum},        33'd0);
        chk("rst2.cout",  {32'd0, cout},      33'd0);
        chk("rst2.valid", {32'd0, out_valid}, 33'd0);

        // random operands against a 33-bit reference sum
        for (int i = 0; i < 300; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom_range(0, 1));
            ref33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            add_vec("rand", ra, rb, rc, ref33[31:0], ref33[32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
